// File: rtl/seq_matmul_mac.sv
// seq_matmul_mac: sequential integer matrix multiplier Z = A*B or Z = C + A*B.
// A is MxK, B is KxN. Operands are read by index from external combinational
// memories. One multiply-accumulate is done per cycle. Results are streamed
// out one element at a time over a strobe/ack handshake, with saturation.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; indices, acc and ovf cleared when start comes
// MAC    | one product a_in*b_in per cycle, k = 0..K-1
// OUT    | z_out/z_stb presented and held until z_ack
// DONE   | single-cycle done pulse, then back to IDLE
module seq_matmul_mac #(
    parameter int M      = 4,
    parameter int K      = 4,
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 1,
    localparam int AW_M  = (M > 1) ? $clog2(M) : 1,
    localparam int AW_K  = (K > 1) ? $clog2(K) : 1,
    localparam int AW_N  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_mode,
    input  logic              abort,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [OUT_W-1:0]  c_in,
    input  logic              z_ack,
    output logic [AW_M-1:0]   a_i,
    output logic [AW_K-1:0]   a_j,
    output logic [AW_K-1:0]   b_i,
    output logic [AW_N-1:0]   b_j,
    output logic [AW_M-1:0]   z_i,
    output logic [AW_N-1:0]   z_j,
    output logic [OUT_W-1:0]  z_out,
    output logic              z_stb,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    if (ACC_W < 2*DATA_W + $clog2(K) + 1) begin : g_acc_too_narrow
        $error("seq_matmul_mac: ACC_W too narrow for DATA_W and K");
    end
    if (OUT_W > ACC_W) begin : g_out_too_wide
        $error("seq_matmul_mac: OUT_W must not exceed ACC_W");
    end

    localparam bit SGN = (SIGNED != 0);
    localparam logic [AW_M-1:0] M_LAST = AW_M'(M - 1);
    localparam logic [AW_K-1:0] K_LAST = AW_K'(K - 1);
    localparam logic [AW_N-1:0] N_LAST = AW_N'(N - 1);
    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [AW_M-1:0]     i;
    logic [AW_K-1:0]     k;
    logic [AW_N-1:0]     j;
    logic [ACC_W-1:0]    acc;
    logic                acc_mode_q;

    logic [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]    prod_ext, c_ext, acc_base, acc_nxt;
    logic [ACC_W-1:0]    hi_bits;
    logic                sat_hit;
    logic [OUT_W-1:0]    sat_val;
    logic                last_elem;

    assign a_i = i;
    assign a_j = k;
    assign b_i = k;
    assign b_j = j;
    assign z_i = i;
    assign z_j = j;

    assign last_elem = (i == M_LAST) && (j == N_LAST);

    // Operand extension, product and the next accumulator value.
    // Extending both operands to 2*DATA_W makes the low half of the product
    // correct for either signedness.
    always_comb begin
        a_ext    = {{DATA_W{SGN & a_in[DATA_W-1]}}, a_in};
        b_ext    = {{DATA_W{SGN & b_in[DATA_W-1]}}, b_in};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-2*DATA_W){SGN & prod[2*DATA_W-1]}}, prod};
        c_ext    = SGN ? ACC_W'($signed(c_in)) : ACC_W'(c_in);
        acc_base = (k == '0) ? (acc_mode_q ? c_ext : '0) : acc;
        acc_nxt  = acc_base + prod_ext;
    end

    // Saturate the freshly completed sum down to OUT_W.
    always_comb begin
        sat_hit = 1'b0;
        sat_val = acc_nxt[OUT_W-1:0];
        hi_bits = '0;
        if (SGN) begin
            hi_bits = $signed(acc_nxt) >>> (OUT_W - 1);
            if (!((hi_bits == '0) || (hi_bits == '1))) begin
                sat_hit = 1'b1;
                sat_val = acc_nxt[ACC_W-1] ? S_MIN : S_MAX;
            end
        end else begin
            hi_bits = acc_nxt >> OUT_W;
            if (hi_bits != '0) begin
                sat_hit = 1'b1;
                sat_val = '1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort wins over z_ack.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_MAC;
            S_MAC: begin
                if (abort)               state_nxt = S_IDLE;
                else if (k == K_LAST)    state_nxt = S_OUT;
            end
            S_OUT: begin
                if (abort)               state_nxt = S_IDLE;
                else if (z_ack)          state_nxt = last_elem ? S_DONE : S_MAC;
            end
            S_DONE:                      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state.
    always_comb begin
        busy  = (state != S_IDLE);
        z_stb = (state == S_OUT);
        done  = (state == S_DONE);
    end

    // Indices, accumulator, held result and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i          <= '0;
            j          <= '0;
            k          <= '0;
            acc        <= '0;
            acc_mode_q <= 1'b0;
            z_out      <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i          <= '0;
                        j          <= '0;
                        k          <= '0;
                        acc        <= '0;
                        ovf        <= 1'b0;
                        acc_mode_q <= acc_mode;
                    end
                end
                S_MAC: begin
                    if (abort) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end else begin
                        acc <= acc_nxt;
                        if (k == K_LAST) begin
                            k     <= '0;
                            z_out <= sat_val;
                            if (sat_hit) ovf <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (abort) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end else if (z_ack) begin
                        if (j == N_LAST) begin
                            j <= '0;
                            i <= (i == M_LAST) ? '0 : i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_matmul_mac.sv
// Testbench for seq_matmul_mac: four instances (2x2 signed, 2x3*3x2 signed,
// 16-bit-output signed and unsigned saturation) driven from a job table,
// plus hand-written abort and reset sequences.
module tb_seq_matmul_mac;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] start;
    logic acc_mode, abort, z_ack;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // operand memories
    logic [15:0] a0 [2][2];
    logic [15:0] b0 [2][2];
    logic [31:0] c0 [2][2];
    logic [15:0] a1 [2][3];
    logic [15:0] b1 [3][2];

    // dut0: 2x2x2 signed
    logic       ai0, aj0, bi0, bj0, zi0, zj0, stb0, busy0, done0, ovf0;
    logic [31:0] z0;
    // dut1: 2x3 * 3x2 signed
    logic       ai1, bj1, zi1, zj1, stb1, busy1, done1, ovf1;
    logic [1:0] aj1, bi1;
    logic [31:0] z1;
    // dut2/dut3: saturation, OUT_W=16
    logic       ai2, aj2, bi2, bj2, zi2, zj2, stb2, busy2, done2, ovf2;
    logic [15:0] z2;
    logic       ai3, aj3, bi3, bj3, zi3, zj3, stb3, busy3, done3, ovf3;
    logic [15:0] z3;

    seq_matmul_mac #(.M(2), .K(2), .N(2), .DATA_W(16), .ACC_W(40), .OUT_W(32), .SIGNED(1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .acc_mode(acc_mode), .abort(abort),
        .a_in(a0[ai0][aj0]), .b_in(b0[bi0][bj0]), .c_in(c0[zi0][zj0]), .z_ack(z_ack),
        .a_i(ai0), .a_j(aj0), .b_i(bi0), .b_j(bj0), .z_i(zi0), .z_j(zj0),
        .z_out(z0), .z_stb(stb0), .busy(busy0), .done(done0), .ovf(ovf0));

    seq_matmul_mac #(.M(2), .K(3), .N(2), .DATA_W(16), .ACC_W(40), .OUT_W(32), .SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .acc_mode(acc_mode), .abort(abort),
        .a_in(a1[ai1][aj1]), .b_in(b1[bi1][bj1]), .c_in(32'd0), .z_ack(z_ack),
        .a_i(ai1), .a_j(aj1), .b_i(bi1), .b_j(bj1), .z_i(zi1), .z_j(zj1),
        .z_out(z1), .z_stb(stb1), .busy(busy1), .done(done1), .ovf(ovf1));

    seq_matmul_mac #(.M(2), .K(2), .N(2), .DATA_W(16), .ACC_W(40), .OUT_W(16), .SIGNED(1)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .acc_mode(acc_mode), .abort(abort),
        .a_in(16'h7FFF), .b_in(16'h7FFF), .c_in(16'd0), .z_ack(z_ack),
        .a_i(ai2), .a_j(aj2), .b_i(bi2), .b_j(bj2), .z_i(zi2), .z_j(zj2),
        .z_out(z2), .z_stb(stb2), .busy(busy2), .done(done2), .ovf(ovf2));

    seq_matmul_mac #(.M(2), .K(2), .N(2), .DATA_W(16), .ACC_W(40), .OUT_W(16), .SIGNED(0)) dut3 (
        .clk(clk), .rst(rst), .start(start[3]), .acc_mode(acc_mode), .abort(abort),
        .a_in(16'hFFFF), .b_in(16'hFFFF), .c_in(16'd0), .z_ack(z_ack),
        .a_i(ai3), .a_j(aj3), .b_i(bi3), .b_j(bj3), .z_i(zi3), .z_j(zj3),
        .z_out(z3), .z_stb(stb3), .busy(busy3), .done(done3), .ovf(ovf3));

    // view of the instance under test
    int   sel;
    logic s_stb, s_busy, s_done, s_ovf;
    int   s_z, s_zi, s_zj, s_aj;

    always_comb begin
        s_stb = 1'b0; s_busy = 1'b0; s_done = 1'b0; s_ovf = 1'b0;
        s_z = 0; s_zi = 0; s_zj = 0; s_aj = 0;
        case (sel)
            0: begin s_stb = stb0; s_busy = busy0; s_done = done0; s_ovf = ovf0;
                     s_z = int'($signed(z0)); s_zi = int'(zi0); s_zj = int'(zj0); s_aj = int'(aj0); end
            1: begin s_stb = stb1; s_busy = busy1; s_done = done1; s_ovf = ovf1;
                     s_z = int'($signed(z1)); s_zi = int'(zi1); s_zj = int'(zj1); s_aj = int'(aj1); end
            2: begin s_stb = stb2; s_busy = busy2; s_done = done2; s_ovf = ovf2;
                     s_z = int'($signed(z2)); s_zi = int'(zi2); s_zj = int'(zj2); s_aj = int'(aj2); end
            default: begin s_stb = stb3; s_busy = busy3; s_done = done3; s_ovf = ovf3;
                     s_z = int'({16'h0, z3}); s_zi = int'(zi3); s_zj = int'(zj3); s_aj = int'(aj3); end
        endcase
    end

    typedef struct {
        int              dut;
        bit              acc;
        int              delay;
        int              kk;
        logic [3:0][31:0] exp;
        bit              exp_ovf;
    } vec_t;

    vec_t vecs [5];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_vec(input int idx, input int dut, input bit acc, input int delay, input int kk,
                           input int e0, input int e1, input int e2, input int e3, input bit ovf);
        vecs[idx].dut     = dut;
        vecs[idx].acc     = acc;
        vecs[idx].delay   = delay;
        vecs[idx].kk      = kk;
        vecs[idx].exp[0]  = 32'(e0);
        vecs[idx].exp[1]  = 32'(e1);
        vecs[idx].exp[2]  = 32'(e2);
        vecs[idx].exp[3]  = 32'(e3);
        vecs[idx].exp_ovf = ovf;
    endtask

    task automatic run_job(input int v);
        vec_t r;
        int   t_start, e, stall;
        bit   done_seen;
        r = vecs[v];
        sel = r.dut;
        z_ack = 1'b0;
        @(negedge clk);
        acc_mode = r.acc;
        start[r.dut] = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = '0;
        acc_mode = 1'b0;
        check($sformatf("job%0d ovf_clear", v), int'(s_ovf), 0);
        check($sformatf("job%0d busy", v), int'(s_busy), 1);
        e = 0; stall = 0; done_seen = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (s_done) begin
                done_seen = 1'b1;
                check($sformatf("job%0d done_time", v), cyc - t_start, 1 + 4*(r.kk + 1 + r.delay));
            end else if (s_stb && e < 4) begin
                if (stall == 0) begin
                    check($sformatf("job%0d z_out[%0d]", v, e), s_z, int'($signed(r.exp[e])));
                    check($sformatf("job%0d z_idx[%0d]", v, e), s_zi*2 + s_zj, e);
                    if (e == 0) check($sformatf("job%0d first_stb", v), cyc - t_start, 1 + r.kk);
                end else begin
                    check($sformatf("job%0d hold[%0d]", v, e),
                          s_z + 1000*(s_zi*2 + s_zj), int'($signed(r.exp[e])) + 1000*e);
                end
                if (stall == r.delay) begin
                    z_ack = 1'b1; e++; stall = 0;
                end else begin
                    z_ack = 1'b0; stall++;
                end
            end else begin
                z_ack = (r.delay == 0);
            end
            if (!done_seen) @(negedge clk);
        end
        z_ack = 1'b0;
        check($sformatf("job%0d done_seen", v), int'(done_seen), 1);
        check($sformatf("job%0d elements", v), e, 4);
        check($sformatf("job%0d ovf", v), int'(s_ovf), int'(r.exp_ovf));
        @(negedge clk);
        check($sformatf("job%0d idle", v), int'(s_busy) + 2*int'(s_done), 0);
        check($sformatf("job%0d ovf_sticky", v), int'(s_ovf), int'(r.exp_ovf));
    endtask

    initial begin
        bit found, done_any;

        a0[0][0] = 16'd1; a0[0][1] = 16'd2; a0[1][0] = 16'd3; a0[1][1] = 16'd4;
        b0[0][0] = 16'd5; b0[0][1] = 16'd6; b0[1][0] = 16'd7; b0[1][1] = 16'd8;
        c0[0][0] = 32'd100; c0[0][1] = -32'sd100; c0[1][0] = 32'd0; c0[1][1] = 32'd1;
        a1[0][0] = 16'd1; a1[0][1] = -16'sd2; a1[0][2] = 16'd3;
        a1[1][0] = 16'd0; a1[1][1] = 16'd4;   a1[1][2] = -16'sd1;
        b1[0][0] = 16'd2;     b1[0][1] = 16'd0;
        b1[1][0] = 16'd1;     b1[1][1] = -16'sd3;
        b1[2][0] = -16'sd1;   b1[2][1] = 16'd5;

        set_vec(0, 0, 1'b0, 0, 2, 19, 22, 43, 50, 1'b0);
        set_vec(1, 1, 1'b0, 0, 3, -3, 21, 5, -17, 1'b0);
        set_vec(2, 0, 1'b1, 3, 2, 119, -78, 43, 51, 1'b0);
        set_vec(3, 2, 1'b0, 0, 2, 32767, 32767, 32767, 32767, 1'b1);
        set_vec(4, 3, 1'b0, 0, 2, 65535, 65535, 65535, 65535, 1'b1);

        sel = 0; start = '0; acc_mode = 1'b0; abort = 1'b0; z_ack = 1'b0;
        rst = 1'b1;
        #12;
        check("reset z_out", s_z, 0);
        check("reset flags", int'(s_stb) + 2*int'(s_busy) + 4*int'(s_done) + 8*int'(s_ovf), 0);
        check("reset idx", s_zi + s_zj + s_aj, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) run_job(v);
        run_job(3);

        // abort during OUT at element (0,1), with z_ack in the same cycle
        sel = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start = '0;
        z_ack = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (s_stb && s_zi == 0 && s_zj == 1) found = 1'b1;
            else @(negedge clk);
        end
        check("abort reached (0,1)", int'(found), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        z_ack = 1'b0;
        check("abort busy", int'(s_busy), 0);
        check("abort z_stb", int'(s_stb), 0);
        check("abort idx", s_zi + s_zj + s_aj, 0);
        done_any = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (s_done) done_any = 1'b1;
            @(negedge clk);
        end
        check("abort no done", int'(done_any), 0);
        run_job(0);

        // start while busy, then asynchronous reset mid-MAC
        sel = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        check("mac k0", s_aj, 0);
        start[0] = 1'b1;
        @(negedge clk);
        start = '0;
        check("start while busy k", s_aj, 1);
        check("start while busy busy", int'(s_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async reset z_out", s_z, 0);
        check("async reset flags", int'(s_stb) + 2*int'(s_busy) + 4*int'(s_done) + 8*int'(s_ovf), 0);
        check("async reset idx", s_zi + s_zj + s_aj, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post reset idle", int'(s_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
